// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit bit engine: SYNC, LSB-first serialisation, bit stuffing,
// NRZI encoding and EOP, advancing one bit per fs_ce strobe.
module usb_tx_serializer #(
   parameter int STUFF_LEN = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fs_ce,
   input  logic [7:0] DataOut_i,
   input  logic       TxValid_i,
   output logic       TxReady_o,
   output logic       txdp,
   output logic       txdn,
   output logic       txoe
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SYNC = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_EOP1 = 3'd3;
   localparam logic [2:0] ST_EOP2 = 3'd4;
   localparam logic [2:0] ST_EOPJ = 3'd5;

   localparam int               CNT_W     = $clog2(STUFF_LEN + 1);
   localparam logic [CNT_W-1:0] STUFF_MAX = CNT_W'(STUFF_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [7:0]       SYNC_BYTE = 8'h80;
   localparam logic [1:0]       LINE_J    = 2'b10;
   localparam logic [1:0]       LINE_SE0  = 2'b00;

   logic [2:0]       state;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic [CNT_W-1:0] ones_cnt;
   logic             eop_pend;

   logic             stuff_due;
   logic             cur_bit;
   logic             start_pkt;
   logic             capture;

   // A 0 toggles the differential line, a 1 holds it.
   function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
      return b ? line : {~line[1], line[1]};
   endfunction

   always_comb begin
      stuff_due = (ones_cnt == STUFF_MAX);
      cur_bit   = shreg[bit_idx];
      start_pkt = fs_ce && (state == ST_IDLE) && TxValid_i;
      capture   = fs_ce && ((state == ST_SYNC) || (state == ST_DATA)) &&
                  !stuff_due && !eop_pend && (bit_idx == 3'd7) && TxValid_i;
   end

   // Byte shifter holds payload only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (start_pkt) begin
         shreg <= SYNC_BYTE;
      end else if (capture) begin
         shreg <= DataOut_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         txdp        <= 1'b1;
         txdn        <= 1'b0;
         txoe        <= 1'b0;
         TxReady_o   <= 1'b0;
         ones_cnt    <= '0;
         bit_idx     <= 3'd0;
         eop_pend    <= 1'b0;
      end else begin
         TxReady_o <= 1'b0;
         if (fs_ce) begin
            case (state)
               ST_IDLE: begin
                  if (TxValid_i) begin
                     state        <= ST_SYNC;
                     txoe         <= 1'b1;
                     {txdp, txdn} <= nrzi({txdp, txdn}, SYNC_BYTE[0]);
                     ones_cnt     <= SYNC_BYTE[0] ? CNT_ONE : '0;
                     bit_idx      <= 3'd1;
                     eop_pend     <= 1'b0;
                  end else begin
                     {txdp, txdn} <= LINE_J;
                     txoe         <= 1'b0;
                     ones_cnt     <= '0;
                  end
               end
               ST_SYNC, ST_DATA: begin
                  // A pending stuff bit pauses the shifter and outranks the EOP.
                  if (stuff_due) begin
                     {txdp, txdn} <= nrzi({txdp, txdn}, 1'b0);
                     ones_cnt     <= '0;
                  end else if (eop_pend) begin
                     {txdp, txdn} <= LINE_SE0;
                     eop_pend     <= 1'b0;
                     state        <= ST_EOP1;
                  end else begin
                     {txdp, txdn} <= nrzi({txdp, txdn}, cur_bit);
                     ones_cnt     <= cur_bit ? ones_cnt + CNT_ONE : '0;
                     bit_idx      <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
                        if (TxValid_i) begin
                           state     <= ST_DATA;
                           TxReady_o <= 1'b1;
                        end else begin
                           eop_pend  <= 1'b1;
                        end
                     end
                  end
               end
               ST_EOP1: begin
                  {txdp, txdn} <= LINE_SE0;
                  state        <= ST_EOP2;
               end
               ST_EOP2: begin
                  {txdp, txdn} <= LINE_J;
                  state        <= ST_EOPJ;
               end
               ST_EOPJ: begin
                  {txdp, txdn} <= LINE_J;
                  txoe         <= 1'b0;
                  ones_cnt     <= '0;
                  state        <= ST_IDLE;
               end
               default: begin
                  {txdp, txdn} <= LINE_J;
                  txoe         <= 1'b0;
                  ones_cnt     <= '0;
                  eop_pend     <= 1'b0;
                  state        <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: directed and random packets compared against a
// bit-stream model of SYNC, stuffing, NRZI and EOP.
module tb_usb_tx_serializer;

   localparam int STUFF_LEN = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fs_ce = 1'b0;
   logic [7:0] DataOut_i = 8'h00;
   logic       TxValid_i = 1'b0;
   logic       TxReady_o;
   logic       txdp;
   logic       txdn;
   logic       txoe;

   int checks = 0;
   int errors = 0;

   logic [7:0] pkt [0:7];
   logic [2:0] exp_sym [$];
   int         exp_rdy [$];
   int         obs_rdy [$];
   int         first_se0;

   usb_tx_serializer #(.STUFF_LEN(STUFF_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .fs_ce     (fs_ce),
      .DataOut_i (DataOut_i),
      .TxValid_i (TxValid_i),
      .TxReady_o (TxReady_o),
      .txdp      (txdp),
      .txdn      (txdn),
      .txoe      (txoe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected per-bit-time symbols {txoe,txdp,txdn} and TxReady bit-time indices.
   task automatic build_model(input int n);
      int   bits [$];
      int   stuffed [$];
      int   ones;
      logic line;
      logic [7:0] b;
      exp_sym.delete();
      exp_rdy.delete();
      for (int j = 0; j <= n; j++) begin
         b = (j == 0) ? 8'h80 : pkt[j-1];
         for (int i = 0; i < 8; i++) bits.push_back(int'(b[i]));
      end
      ones = 0;
      for (int k = 0; k < bits.size(); k++) begin
         if (ones == STUFF_LEN) begin
            stuffed.push_back(0);
            ones = 0;
         end
         stuffed.push_back(bits[k]);
         ones = (bits[k] != 0) ? ones + 1 : 0;
         if ((k % 8 == 7) && (k / 8 < n)) exp_rdy.push_back(stuffed.size() - 1);
      end
      if (ones == STUFF_LEN) stuffed.push_back(0);
      line = 1'b1;
      foreach (stuffed[k]) begin
         if (stuffed[k] == 0) line = ~line;
         exp_sym.push_back({1'b1, line, ~line});
      end
      exp_sym.push_back(3'b100);
      exp_sym.push_back(3'b100);
      exp_sym.push_back(3'b110);
      exp_sym.push_back(3'b010);
      exp_sym.push_back(3'b010);
   endtask

   task automatic idle(input int nb);
      TxValid_i = 1'b0;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         fs_ce = 1'b1;
         @(posedge clk);
         #1;
         chk("idle_line", 32'({txoe, txdp, txdn}), 32'(3'b010));
      end
      @(negedge clk);
      fs_ce = 1'b0;
   endtask

   task automatic run_packet(input string tag, input int n, input int period, input int abort_pulse);
      int         idx;
      int         pulses;
      int         cyc;
      logic       prev_rdy;
      logic [2:0] prev_out;
      build_model(n);
      obs_rdy.delete();
      first_se0 = -1;
      idx = 0;
      pulses = 0;
      cyc = 0;
      prev_rdy = 1'b0;
      @(negedge clk);
      DataOut_i = pkt[0];
      TxValid_i = 1'b1;
      prev_out = {txoe, txdp, txdn};
      while (idx < exp_sym.size()) begin
         fs_ce = (cyc % period == 0);
         @(posedge clk);
         #1;
         if (prev_rdy) chk($sformatf("%s rdy_width", tag), 32'(TxReady_o), 32'(1'b0));
         if (fs_ce) begin
            chk($sformatf("%s sym%0d", tag, idx), 32'({txoe, txdp, txdn}), 32'(exp_sym[idx]));
            if ({txdp, txdn} == 2'b00 && first_se0 < 0) first_se0 = idx;
            if (TxReady_o && !prev_rdy) obs_rdy.push_back(idx);
            idx++;
         end else begin
            chk($sformatf("%s hold", tag), 32'({txoe, txdp, txdn}), 32'(prev_out));
            if (TxReady_o && !prev_rdy) obs_rdy.push_back(-1);
         end
         if (TxReady_o && !prev_rdy) pulses++;
         prev_rdy = TxReady_o;
         prev_out = {txoe, txdp, txdn};
         if (abort_pulse > 0 && pulses == abort_pulse) begin
            #1;
            rst = 1'b1;
            TxValid_i = 1'b0;
            fs_ce = 1'b0;
            #1;
            chk($sformatf("%s rst_dp", tag), 32'(txdp), 32'(1'b1));
            chk($sformatf("%s rst_dn", tag), 32'(txdn), 32'(1'b0));
            chk($sformatf("%s rst_oe", tag), 32'(txoe), 32'(1'b0));
            chk($sformatf("%s rst_rdy", tag), 32'(TxReady_o), 32'(1'b0));
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         cyc++;
         TxValid_i = (pulses < n);
         if (pulses < n) DataOut_i = pkt[pulses];
      end
      fs_ce = 1'b0;
      TxValid_i = 1'b0;
      chk($sformatf("%s rdy_count", tag), 32'(obs_rdy.size()), 32'(exp_rdy.size()));
      foreach (exp_rdy[i])
         if (i < obs_rdy.size()) chk($sformatf("%s rdy%0d_pos", tag, i), 32'(obs_rdy[i]), 32'(exp_rdy[i]));
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("reset_dp", 32'(txdp), 32'(1'b1));
      chk("reset_dn", 32'(txdn), 32'(1'b0));
      chk("reset_oe", 32'(txoe), 32'(1'b0));
      chk("reset_rdy", 32'(TxReady_o), 32'(1'b0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      pkt[0] = 8'h00;
      run_packet("byte00", 1, 1, 0);
      idle(2);

      pkt[0] = 8'hFF;
      run_packet("byteFF", 1, 1, 0);
      chk("byteFF se0_at", 32'(first_se0), 32'(17));
      idle(2);

      pkt[0] = 8'h3F;
      pkt[1] = 8'h01;
      run_packet("two3F01", 2, 1, 0);
      chk("two3F01 rdy_gap", 32'((obs_rdy.size() >= 2) ? obs_rdy[1] - obs_rdy[0] : -1), 32'(9));
      idle(2);

      pkt[0] = 8'hA5;
      run_packet("sparseA5", 1, 4, 0);
      idle(2);

      run_packet("sync_only", 0, 1, 0);
      idle(2);

      pkt[0] = 8'hFF;
      pkt[1] = 8'hFF;
      pkt[2] = 8'hFF;
      run_packet("abort", 3, 1, 2);
      idle(3);
      pkt[0] = 8'hFF;
      run_packet("after_rst", 1, 1, 0);
      idle(2);

      for (int r = 0; r < 8; r++) begin
         int n;
         int period;
         n = $urandom_range(0, 4);
         period = $urandom_range(1, 4);
         for (int i = 0; i < 8; i++) pkt[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
         run_packet($sformatf("rand%0d", r), n, period, 0);
         idle(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
